// File: rtl/sft_pkg.sv
// rtl/sft_pkg.sv - shared state type, default sizes and helpers for the SFT frame sequencer
//
// Contents:
//   *_DEF localparams : default sizing used by sft_frame_sequencer parameters
//   sft_state_e       : sequencer state encoding, shared with sft_tx_handshake
//   wrap_inc()        : modulo increment used for the window column index
package sft_pkg;

   localparam int         NUM_BINS_DEF     = 8;
   localparam int         BIN_W_DEF        = 3;
   localparam int         WINDOW_WIDTH_DEF = 11;
   localparam int         COL_W_DEF        = 4;
   localparam int         TIME_W_DEF       = 8;
   localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_WAIT_CORE,
      ST_TX_ADDR,
      ST_TX_LOAD,
      ST_TX_WAIT_HI,
      ST_TX_WAIT_LO,
      ST_CLEAR,
      ST_ADVANCE
   } sft_state_e;

   // Increment that wraps to zero after modulo-1.
   function automatic int wrap_inc(input int value, input int modulo);
      return (value == modulo - 1) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/sft_tx_handshake.sv
// rtl/sft_tx_handshake.sv - one-byte tx_start/tx_busy handshake towards the byte transmitter
//
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   req_i          : one-cycle request to send data_i (data_i valid from the next cycle on)
//   data_i         : byte to send, captured when the transmitter is idle
//   tx_busy_i      : transmitter busy
//   tx_start_o     : one-cycle start pulse, aligned with tx_data_o
//   tx_data_o      : registered byte to transmit
//   byte_done_o    : one-cycle pulse when tx_busy_i falls after the start
//   phase_d_o      : next handshake phase (ST_IDLE, ST_TX_LOAD, ST_TX_WAIT_HI, ST_TX_WAIT_LO)
module sft_tx_handshake
   import sft_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   input  logic [7:0] data_i,
   input  logic       tx_busy_i,
   output logic       tx_start_o,
   output logic [7:0] tx_data_o,
   output logic       byte_done_o,
   output sft_state_e phase_d_o
);

   sft_state_e phase_q, phase_d;
   logic       tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         phase_q    <= ST_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         phase_q    <= phase_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_comb begin
      phase_d     = phase_q;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      byte_done_o = 1'b0;
      unique case (phase_q)
         ST_IDLE: begin
            if (req_i) phase_d = ST_TX_LOAD;
         end
         ST_TX_LOAD: begin
            // Start and data are both registered so they reach the transmitter together.
            if (!tx_busy_i) begin
               tx_data_d  = data_i;
               tx_start_d = 1'b1;
               phase_d    = ST_TX_WAIT_HI;
            end
         end
         ST_TX_WAIT_HI: begin
            if (tx_busy_i) phase_d = ST_TX_WAIT_LO;
         end
         ST_TX_WAIT_LO: begin
            if (!tx_busy_i) begin
               byte_done_o = 1'b1;
               phase_d     = ST_IDLE;
            end
         end
         default: phase_d = ST_IDLE;
      endcase
   end

   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign phase_d_o  = phase_d;

endmodule

// File: rtl/sft_frame_sequencer.sv
// rtl/sft_frame_sequencer.sv - sequences accumulate, result streaming and column clear per sample
//
// Build option: SFT_SEQ_SYNC_HEADER_EN prefixes every frame with SYNC_BYTE.
//
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   sample_valid/_data/_ready    : sample input handshake
//   core_start, core_sample      : accumulate request and latched sample
//   core_col, core_time          : current window column and time index
//   core_done                    : accumulate pass finished (used only while waiting for it)
//   core_clear                   : zero column core_col
//   bin_addr, bin_data           : result read port (one-cycle read latency)
//   tx_start, tx_data, tx_busy   : byte transmitter handshake
//   overrun, overrun_clr         : sticky sample-while-busy flag and its clear
module sft_frame_sequencer
   import sft_pkg::*;
#(
   parameter int         NUM_BINS     = NUM_BINS_DEF,
   parameter int         BIN_W        = BIN_W_DEF,
   parameter int         WINDOW_WIDTH = WINDOW_WIDTH_DEF,
   parameter int         COL_W        = COL_W_DEF,
   parameter int         TIME_W       = TIME_W_DEF,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [7:0]        sample_data,
   output logic              sample_ready,
   output logic              core_start,
   output logic [7:0]        core_sample,
   output logic [COL_W-1:0]  core_col,
   output logic [TIME_W-1:0] core_time,
   input  logic              core_done,
   output logic              core_clear,
   output logic [BIN_W-1:0]  bin_addr,
   input  logic [7:0]        bin_data,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              overrun,
   input  logic              overrun_clr
);

`ifdef SFT_SEQ_SYNC_HEADER_EN
   localparam logic HDR_EN = 1'b1;
`else
   localparam logic HDR_EN = 1'b0;
`endif

   sft_state_e        state_q, state_d;
   logic [7:0]        core_sample_q, core_sample_d;
   logic [COL_W-1:0]  core_col_q, core_col_d;
   logic [TIME_W-1:0] core_time_q, core_time_d;
   logic [BIN_W-1:0]  bin_addr_q, bin_addr_d;
   logic              hdr_pend_q, hdr_pend_d;
   logic              overrun_q, overrun_d;

   logic              hs_req;
   logic [7:0]        hs_data;
   logic              byte_done;
   sft_state_e        hs_phase_d;
   logic              last_bin;
   logic              overrun_set;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         core_sample_q <= 8'h00;
         core_col_q    <= '0;
         core_time_q   <= '0;
         bin_addr_q    <= '0;
         hdr_pend_q    <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_sample_q <= core_sample_d;
         core_col_q    <= core_col_d;
         core_time_q   <= core_time_d;
         bin_addr_q    <= bin_addr_d;
         hdr_pend_q    <= hdr_pend_d;
         overrun_q     <= overrun_d;
      end
   end

   assign last_bin = (bin_addr_q == BIN_W'(NUM_BINS - 1));

   // The header byte, when pending, goes out before bin 0 through the same handshake.
   assign hs_data = hdr_pend_q ? SYNC_BYTE : bin_data;

   always_comb begin
      state_d       = state_q;
      core_sample_d = core_sample_q;
      core_col_d    = core_col_q;
      core_time_d   = core_time_q;
      bin_addr_d    = bin_addr_q;
      hdr_pend_d    = hdr_pend_q;
      hs_req        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               core_sample_d = sample_data;
               state_d       = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            state_d = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            if (core_done) begin
               bin_addr_d = '0;
               hdr_pend_d = HDR_EN;
               state_d    = ST_TX_ADDR;
            end
         end
         ST_TX_ADDR: begin
            // bin_addr settled this cycle; bin_data is valid by the time the handshake loads.
            hs_req  = 1'b1;
            state_d = ST_TX_LOAD;
         end
         ST_TX_LOAD, ST_TX_WAIT_HI, ST_TX_WAIT_LO: begin
            // The handshake owns these phases; this FSM only decides what follows a byte.
            if (byte_done) begin
               if (hdr_pend_q) begin
                  hdr_pend_d = 1'b0;
                  state_d    = ST_TX_ADDR;
               end else if (last_bin) begin
                  state_d = ST_CLEAR;
               end else begin
                  bin_addr_d = bin_addr_q + BIN_W'(1);
                  state_d    = ST_TX_ADDR;
               end
            end else begin
               state_d = hs_phase_d;
            end
         end
         ST_CLEAR: begin
            state_d = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            core_col_d  = COL_W'(wrap_inc(int'(core_col_q), WINDOW_WIDTH));
            core_time_d = core_time_q + TIME_W'(1);
            bin_addr_d  = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new violation in the same cycle as a clear keeps the flag set.
   assign overrun_set = sample_valid && !sample_ready;

   always_comb begin
      overrun_d = overrun_q;
      if (overrun_set)      overrun_d = 1'b1;
      else if (overrun_clr) overrun_d = 1'b0;
   end

   sft_tx_handshake u_tx_hs (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (hs_req),
      .data_i      (hs_data),
      .tx_busy_i   (tx_busy),
      .tx_start_o  (tx_start),
      .tx_data_o   (tx_data),
      .byte_done_o (byte_done),
      .phase_d_o   (hs_phase_d)
   );

   assign sample_ready = rst_n && (state_q == ST_IDLE);
   assign core_start   = (state_q == ST_ACCUM);
   assign core_clear   = (state_q == ST_CLEAR);
   assign core_sample  = core_sample_q;
   assign core_col     = core_col_q;
   assign core_time    = core_time_q;
   assign bin_addr     = bin_addr_q;
   assign overrun      = overrun_q;

endmodule
